mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory access controller for the 16-bit processor. It connects the instruction-fetch port and the load/store port to the single-ported, negedge-clocked program/data RAM. It arbitrates between the two requesters and sequences each access with a req/ack handshake. It registers the read data returned by the RAM and flags accesses outside the populated address range.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_DEPTH, 9, number of populated RAM words; valid addresses are 0..MEM_DEPTH-1

Ports:
- i_clk  in  1  system clock; controller is posedge, RAM is negedge
- i_rst_n  in  1  reset; asynchronous, active-low
- i_if_req  in  1  fetch request, held until ack
- i_if_addr  in  ADDR_W  fetch address
- o_if_ack  out  1  one-cycle fetch completion pulse
- o_if_data  out  DATA_W  fetched instruction word
- o_if_err  out  1  fetch address out of range; valid with ack
- i_ls_req  in  1  load/store request, held until ack
- i_ls_we  in  1  1 = store, 0 = load
- i_ls_addr  in  ADDR_W  load/store address
- i_ls_wdata  in  DATA_W  store data
- o_ls_ack  out  1  one-cycle load/store completion pulse
- o_ls_rdata  out  DATA_W  load data
- o_ls_err  out  1  load/store address out of range; valid with ack
- o_mem_we  out  1  RAM write enable
- o_mem_addr  out  ADDR_W  RAM address
- o_mem_wdata  out  DATA_W  RAM write data
- i_mem_rdata  in  DATA_W  RAM read data, updated on the RAM's negedge
- o_busy  out  1  high when the state is not IDLE

## Operation
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - Sample the requests.
  - If any request is pending, latch the winner's port id, address, we and wdata, then go to ACCESS.
  - If no request is pending, stay in IDLE.
- Arbitration:
  - Only one request pending: grant it.
  - Both pending: grant the port not granted last (alternation). A last_grant register records the previous grant. Its reset value is "fetch", so load/store wins the first conflict.
- ACCESS:
  - o_mem_addr and o_mem_wdata come from the latched request.
  - o_mem_we = latched we AND address in range.
  - The fetch port is always a read.
  - Go to ACK.
- ACK:
  - Pulse the granted port's ack.
  - For a read, o_*_data takes the value of i_mem_rdata captured at the posedge ending ACCESS.
  - For a store, o_ls_rdata is unchanged. The RAM returns the pre-write word, and that value is discarded.
  - Out-of-range access: the err flag is 1, data is 0, and no write is performed.
  - Go to IDLE. Requests are not sampled in ACK.
- Requester rule: deassert req, or present a new request, in the cycle after ack. The controller only re-samples in IDLE.
- In-range test: addr < MEM_DEPTH, evaluated on the full ADDR_W address with no truncation or wrap.
- Reset (async): state = IDLE, last_grant = fetch. All outputs are 0, including o_mem_addr, o_mem_wdata and both data outputs.
- Reset asserted mid-access: o_mem_we drops immediately and no ack is issued. The requester must re-issue after reset.

## Timing
- Cycle n: req sampled in IDLE.
- Cycle n+1: ACCESS. RAM acts at the negedge inside this cycle.
- Cycle n+2: ack high for exactly one cycle, data and err valid.
- Latency from req sampled to ack is 2 cycles. Peak throughput is one access per 3 cycles.
- o_mem_we is high only during ACCESS and only for an in-range store. It is registered, so the RAM sees a stable level at its negedge.
- Back-to-back: a request held or newly asserted in the cycle after ack (IDLE) is accepted in that cycle.
- Data outputs hold their value between acks. The err flags are meaningful only while the corresponding ack is high.

## Structure
- Package mem_ctrl_pkg:
  - state enum (IDLE, ACCESS, ACK)
  - port-id constants (PORT_IF, PORT_LS)
  - ADDR_W/DATA_W defaults shared with the RAM and core
- One sub-module: mem_arb. A two-requester alternating-priority arbiter with a last_grant register, producing grant_if / grant_ls when enabled in IDLE.
- Everything else (FSM, request latch, response registers, range check) lives in mem_ctrl.

## Test plan
- Reset:
  - Stimulus: hold i_rst_n=0 with random requests driving the inputs.
  - Response: all outputs 0, o_busy=0. After release, the first ack arrives exactly 2 cycles after the first sampled req.
- Fetch read:
  - Stimulus: RAM word 0 = 0x80FE; if_req with addr 0.
  - Response: o_if_ack pulse at n+2, o_if_data=0x80FE, o_if_err=0, o_mem_we never high.
- Store then load:
  - Stimulus: store 0x1234 to addr 7, then load addr 7.
  - Response: one o_mem_we pulse with addr 7. Store ack leaves o_ls_rdata unchanged. Load ack returns 0x1234.
- Simultaneous requests:
  - Stimulus: if_req and ls_req asserted together, both re-requesting immediately after each ack.
  - Response: grant order ls, if, ls, if. Each ack is 3 cycles after the previous one.
- Out of range:
  - Stimulus: store 0xFFFF to addr 9, then load addr 0x8000.
  - Response: both acks have err=1 and data 0. o_mem_we stays 0. RAM contents are unchanged.
- Reset mid-access:
  - Stimulus: drop i_rst_n during ACCESS of a store.
  - Response: o_mem_we falls asynchronously, no ack, state IDLE.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
// Width defaults here match the RAM and the core.
package mem_ctrl_pkg;

  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_MEM_DEPTH = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

endpackage

// File: rtl/mem_arb.sv
// Two-requester arbiter: a lone request wins; on a conflict the port not
// granted last time wins. The grant is only produced while en is high.
module mem_arb
  import mem_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_if,
  input  logic req_ls,
  output logic grant_if,
  output logic grant_ls
);

  logic last_grant;

  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (en) begin
      if (req_if && req_ls) begin
        if (last_grant == PORT_IF) grant_ls = 1'b1;
        else                       grant_if = 1'b1;
      end else begin
        grant_if = req_if;
        grant_ls = req_ls;
      end
    end
  end

  // Reset to fetch so load/store takes the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= PORT_IF;
    end else if (grant_ls) begin
      last_grant <= PORT_LS;
    end else if (grant_if) begin
      last_grant <= PORT_IF;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory access controller: arbitrates fetch vs load/store onto the single
// negedge-clocked RAM, one access per three cycles, with range checking.
//
//   state  | meaning
//   IDLE   | sample requests, latch the winner
//   ACCESS | drive RAM address/data/we; RAM acts at the mid-cycle negedge
//   ACK    | one-cycle ack to the granted port, response data valid
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ack,
  output logic [DATA_W-1:0] o_if_data,
  output logic              o_if_err,
  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [DATA_W-1:0] i_ls_wdata,
  output logic              o_ls_ack,
  output logic [DATA_W-1:0] o_ls_rdata,
  output logic              o_ls_err,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

  state_t            state, state_nxt;
  logic              arb_en;
  logic              grant_if, grant_ls;
  logic              latch_en;
  logic [ADDR_W-1:0] req_addr;
  logic              req_oor;
  logic              lat_port;
  logic              lat_we;
  logic              lat_oor;

  mem_arb u_arb (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .en       (arb_en),
    .req_if   (i_if_req),
    .req_ls   (i_ls_req),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  // Full-width compare: high addresses must not alias onto populated words.
  assign req_addr = grant_ls ? i_ls_addr : i_if_addr;
  assign req_oor  = (req_addr >= DEPTH_A);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arb_en    = 1'b0;
    latch_en  = 1'b0;
    case (state)
      IDLE: begin
        arb_en = 1'b1;
        if (grant_if || grant_ls) begin
          latch_en  = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);

  // Request latch doubles as the RAM drive; we is registered so the RAM
  // sees a stable level at its negedge and is high only during ACCESS.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_we    <= 1'b0;
      lat_port    <= PORT_IF;
      lat_we      <= 1'b0;
      lat_oor     <= 1'b0;
    end else begin
      o_mem_we <= 1'b0;
      if (latch_en) begin
        o_mem_addr  <= req_addr;
        o_mem_wdata <= grant_ls ? i_ls_wdata : '0;
        o_mem_we    <= grant_ls && i_ls_we && !req_oor;
        lat_port    <= grant_ls ? PORT_LS : PORT_IF;
        lat_we      <= grant_ls && i_ls_we;
        lat_oor     <= req_oor;
      end
    end
  end

  // RAM data is captured at the edge that ends ACCESS; a store's pre-write
  // word is dropped so o_ls_rdata keeps the last load result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_if_ack   <= 1'b0;
      o_if_err   <= 1'b0;
      o_if_data  <= '0;
      o_ls_ack   <= 1'b0;
      o_ls_err   <= 1'b0;
      o_ls_rdata <= '0;
    end else begin
      o_if_ack <= 1'b0;
      o_if_err <= 1'b0;
      o_ls_ack <= 1'b0;
      o_ls_err <= 1'b0;
      if (state == ACCESS) begin
        if (lat_port == PORT_LS) begin
          o_ls_ack <= 1'b1;
          o_ls_err <= lat_oor;
          if (lat_oor)     o_ls_rdata <= '0;
          else if (!lat_we) o_ls_rdata <= i_mem_rdata;
        end else begin
          o_if_ack  <= 1'b1;
          o_if_err  <= lat_oor;
          o_if_data <= lat_oor ? '0 : i_mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed scenarios plus random traffic, checked each
// cycle against a transaction-level model with a negedge RAM behind the DUT.
module tb_mem_ctrl;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_if_req;
  logic [15:0] i_if_addr;
  logic        o_if_ack;
  logic [15:0] o_if_data;
  logic        o_if_err;
  logic        i_ls_req;
  logic        i_ls_we;
  logic [15:0] i_ls_addr;
  logic [15:0] i_ls_wdata;
  logic        o_ls_ack;
  logic [15:0] o_ls_rdata;
  logic        o_ls_err;
  logic        o_mem_we;
  logic [15:0] o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic [15:0] i_mem_rdata;
  logic        o_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [15:0] seed;

  mem_ctrl #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(9)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .o_if_ack    (o_if_ack),
    .o_if_data   (o_if_data),
    .o_if_err    (o_if_err),
    .i_ls_req    (i_ls_req),
    .i_ls_we     (i_ls_we),
    .i_ls_addr   (i_ls_addr),
    .i_ls_wdata  (i_ls_wdata),
    .o_ls_ack    (o_ls_ack),
    .o_ls_rdata  (o_ls_rdata),
    .o_ls_err    (o_ls_err),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata),
    .o_busy      (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] init_word(int i);
    if (i == 0) return 16'h80FE;
    return seed ^ 16'(i * 16'h1357);
  endfunction

  // Negedge RAM: writes when we is high, returns the pre-write word.
  logic [15:0] ram [0:8];
  bit ram_ready = 0;
  always @(negedge i_clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 9; i++) ram[i] <= init_word(i);
      ram_ready <= 1'b1;
    end else if (o_mem_we && o_mem_addr < 16'd9) begin
      ram[int'(o_mem_addr)] <= o_mem_wdata;
    end
    i_mem_rdata <= (o_mem_addr < 16'd9) ? ram[int'(o_mem_addr)] : 16'hDEAD;
  end

  // Transaction model: an accepted request acks 2 cycles later; the next
  // sample happens 3 cycles after the previous one.
  logic [15:0] ref_mem [0:8];
  bit          ref_ready = 0;
  bit          act = 0;
  bit          last_ls = 0;
  int          g_cyc = 0;
  bit          g_ls, g_we, g_oor;
  logic [15:0] g_addr, g_wdata, g_rd;
  logic [15:0] exp_if_data = '0;
  logic [15:0] exp_ls_rdata = '0;
  bit          e_acc, e_ack;

  always @(negedge i_clk) begin
    if (!ref_ready) begin
      for (int i = 0; i < 9; i++) ref_mem[i] = init_word(i);
      ref_ready = 1;
    end
    if (!i_rst_n) begin
      act = 0;
      last_ls = 0;
      exp_if_data = '0;
      exp_ls_rdata = '0;
      chk("rst_if_ack", o_if_ack, 0);
      chk("rst_ls_ack", o_ls_ack, 0);
      chk("rst_if_err", o_if_err, 0);
      chk("rst_ls_err", o_ls_err, 0);
      chk("rst_if_data", o_if_data, 0);
      chk("rst_ls_rdata", o_ls_rdata, 0);
      chk("rst_mem_we", o_mem_we, 0);
      chk("rst_mem_addr", o_mem_addr, 0);
      chk("rst_mem_wdata", o_mem_wdata, 0);
      chk("rst_busy", o_busy, 0);
    end else begin
      e_acc = act && (cyc == g_cyc + 1);
      e_ack = act && (cyc == g_cyc + 2);
      if (e_ack) begin
        if (g_ls) begin
          if (g_oor)      exp_ls_rdata = '0;
          else if (!g_we) exp_ls_rdata = g_rd;
        end else begin
          exp_if_data = g_oor ? 16'h0 : g_rd;
        end
      end
      chk("if_ack", o_if_ack, e_ack && !g_ls);
      chk("ls_ack", o_ls_ack, e_ack && g_ls);
      chk("busy", o_busy, e_acc || e_ack);
      chk("mem_we", o_mem_we, e_acc && g_we && !g_oor);
      if (e_acc) chk("mem_addr", o_mem_addr, g_addr);
      if (e_acc && g_we) chk("mem_wdata", o_mem_wdata, g_wdata);
      if (e_ack && !g_ls) chk("if_err", o_if_err, g_oor);
      if (e_ack && g_ls) chk("ls_err", o_ls_err, g_oor);
      chk("if_data", o_if_data, exp_if_data);
      chk("ls_rdata", o_ls_rdata, exp_ls_rdata);

      if (e_ack) begin
        act = 0;
      end else if (!act && (i_if_req || i_ls_req)) begin
        if (i_if_req && i_ls_req) g_ls = !last_ls;
        else                      g_ls = i_ls_req;
        last_ls = g_ls;
        g_addr  = g_ls ? i_ls_addr : i_if_addr;
        g_we    = g_ls && i_ls_we;
        g_wdata = i_ls_wdata;
        g_oor   = (int'(g_addr) >= 9);
        g_rd    = '0;
        if (!g_oor) begin
          if (g_we) ref_mem[int'(g_addr)] = g_wdata;
          else      g_rd = ref_mem[int'(g_addr)];
        end
        act = 1;
        g_cyc = cyc;
      end
    end
  end

  function automatic logic [15:0] rnd_addr();
    case ($urandom_range(0, 9))
      0: return 16'd9;
      1: return 16'h8000;
      2: return 16'($urandom);
      default: return 16'($urandom_range(0, 8));
    endcase
  endfunction

  task automatic do_req(input bit ls, input bit we, input logic [15:0] addr,
                        input logic [15:0] wd, output logic [15:0] d, output bit e);
    bit got;
    got = 0;
    d = '0;
    e = 0;
    @(posedge i_clk); #1;
    if (ls) begin
      i_ls_req = 1; i_ls_we = we; i_ls_addr = addr; i_ls_wdata = wd;
    end else begin
      i_if_req = 1; i_if_addr = addr;
    end
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge i_clk);
      if (ls ? o_ls_ack : o_if_ack) begin
        got = 1;
        d = ls ? o_ls_rdata : o_if_data;
        e = ls ? o_ls_err : o_if_err;
      end
    end
    chk(ls ? "ls_done" : "if_done", got, 1);
    @(posedge i_clk); #1;
    i_if_req = 0; i_ls_req = 0; i_ls_we = 0;
  endtask

  logic [15:0] d;
  bit          e, got, a_if, a_ls;
  int          c0, n;
  int          ack_cyc [4];
  bit          ack_ls  [4];

  initial begin
    seed = 16'($urandom);
    i_rst_n = 0;
    i_if_req = 0; i_if_addr = '0;
    i_ls_req = 0; i_ls_we = 0; i_ls_addr = '0; i_ls_wdata = '0;

    // Reset held with random traffic on the inputs.
    repeat (6) begin
      @(posedge i_clk); #1;
      i_if_req = 1'($urandom); i_if_addr = 16'($urandom);
      i_ls_req = 1'($urandom); i_ls_we = 1'($urandom);
      i_ls_addr = 16'($urandom); i_ls_wdata = 16'($urandom);
    end
    @(posedge i_clk); #1;
    i_if_req = 0; i_ls_req = 0; i_ls_we = 0;
    i_rst_n = 1;

    // Simultaneous loads right after reset: ls, if, ls, if, 3 cycles apart.
    @(posedge i_clk); #1;
    c0 = cyc;
    i_if_req = 1; i_if_addr = 16'd1;
    i_ls_req = 1; i_ls_we = 0; i_ls_addr = 16'd2;
    n = 0;
    for (int k = 0; k < 20 && n < 4; k++) begin
      @(negedge i_clk);
      if (o_if_ack || o_ls_ack) begin
        ack_cyc[n] = cyc;
        ack_ls[n] = o_ls_ack;
        n++;
      end
    end
    @(posedge i_clk); #1;
    i_if_req = 0; i_ls_req = 0;
    chk("sim_count", n, 4);
    if (n > 0) chk("first_latency", ack_cyc[0] - c0, 2);
    for (int i = 0; i < n; i++) chk("sim_order", ack_ls[i], (i % 2) == 0);
    for (int i = 1; i < n; i++) chk("sim_gap", ack_cyc[i] - ack_cyc[i-1], 3);

    // Fetch read of word 0.
    do_req(0, 0, 16'd0, 16'h0, d, e);
    chk("fetch_data", d, 16'h80FE);
    chk("fetch_err", e, 0);

    // Store then load.
    do_req(1, 1, 16'd7, 16'h1234, d, e);
    chk("store_err", e, 0);
    do_req(1, 0, 16'd7, 16'h0, d, e);
    chk("load_data", d, 16'h1234);

    // Out-of-range store and load.
    do_req(1, 1, 16'd9, 16'hFFFF, d, e);
    chk("oor_st_err", e, 1);
    chk("oor_st_data", d, 0);
    do_req(1, 0, 16'h8000, 16'h0, d, e);
    chk("oor_ld_err", e, 1);
    chk("oor_ld_data", d, 0);
    do_req(0, 0, 16'hFFFF, 16'h0, d, e);
    chk("oor_if_err", e, 1);
    chk("oor_if_data", d, 0);

    // Reset dropped during ACCESS of a store.
    @(posedge i_clk); #1;
    i_ls_req = 1; i_ls_we = 1; i_ls_addr = 16'd3; i_ls_wdata = 16'($urandom);
    got = 0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge i_clk);
      if (o_mem_we) got = 1;
    end
    chk("mid_we_seen", got, 1);
    #2 i_rst_n = 0;
    #1;
    chk("mid_we_drop", o_mem_we, 0);
    chk("mid_busy", o_busy, 0);
    chk("mid_ls_ack", o_ls_ack, 0);
    @(posedge i_clk); #1;
    i_ls_req = 0; i_ls_we = 0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1;
    do_req(1, 1, 16'd3, 16'hBEEF, d, e);
    do_req(1, 0, 16'd3, 16'h0, d, e);
    chk("reissue_data", d, 16'hBEEF);

    // Random traffic; each requester holds until ack, then drops or re-issues.
    for (int k = 0; k < 460; k++) begin
      @(negedge i_clk);
      a_if = o_if_ack;
      a_ls = o_ls_ack;
      @(posedge i_clk); #1;
      if (a_if || !i_if_req) begin
        if (k < 420 && $urandom_range(0, 2) != 0) begin
          i_if_req = 1; i_if_addr = rnd_addr();
        end else begin
          i_if_req = 0;
        end
      end
      if (a_ls || !i_ls_req) begin
        if (k < 420 && $urandom_range(0, 2) != 0) begin
          i_ls_req = 1; i_ls_we = 1'($urandom); i_ls_addr = rnd_addr();
          i_ls_wdata = 16'($urandom);
        end else begin
          i_ls_req = 0; i_ls_we = 0;
        end
      end
    end
    i_if_req = 0; i_ls_req = 0;
    repeat (4) @(posedge i_clk);
    @(negedge i_clk);
    #1;
    for (int i = 0; i < 9; i++) chk("ram_word", ram[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
